// File: rtl/aud_mode_ctrl.sv
// Top-level sequencer for the audio record/playback path: turns debounced key
// pulses into start/pause/stop pulses for the recorder and player/DSP, owns
// the single SRAM port and latches the recording end address for playback.
// Ports: i_clk/i_rst_n; i_init_done; key pulses i_key_*; i_mode_rec;
//   recorder side o_rec_* / i_rec_addr / i_rec_data; player side o_play_* /
//   i_play_addr / i_play_done; o_end_addr, o_rec_valid; SRAM o_sram_*;
//   o_state for display.
module aud_mode_ctrl #(
   parameter int                 ADDR_W   = 20,
   parameter logic [ADDR_W-1:0]  MAX_ADDR = {ADDR_W{1'b1}}
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_init_done,
   input  logic              i_key_start,
   input  logic              i_key_pause,
   input  logic              i_key_stop,
   input  logic              i_mode_rec,
   output logic              o_rec_start,
   output logic              o_rec_pause,
   output logic              o_rec_stop,
   input  logic [ADDR_W-1:0] i_rec_addr,
   input  logic [15:0]       i_rec_data,
   output logic              o_play_start,
   output logic              o_play_pause,
   output logic              o_play_stop,
   input  logic [ADDR_W-1:0] i_play_addr,
   input  logic              i_play_done,
   output logic [ADDR_W-1:0] o_end_addr,
   output logic              o_rec_valid,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic              o_sram_we_n,
   output logic [15:0]       o_sram_wdata,
   output logic [2:0]        o_state
);

   typedef enum logic [2:0] {
      S_INIT       = 3'd0,
      S_IDLE       = 3'd1,
      S_REC        = 3'd2,
      S_REC_PAUSE  = 3'd3,
      S_PLAY       = 3'd4,
      S_PLAY_PAUSE = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] end_addr_q, end_addr_d;
   logic              rec_valid_q, rec_valid_d;
   logic              rec_start_q, rec_start_d;
   logic              rec_pause_q, rec_pause_d;
   logic              rec_stop_q, rec_stop_d;
   logic              play_start_q, play_start_d;
   logic              play_pause_q, play_pause_d;
   logic              play_stop_q, play_stop_d;

   // Key priority stop > pause > start: start only counts when neither of the
   // higher-priority keys is pressed in the same cycle, even in states where
   // those higher keys themselves do nothing.
   logic start_eff;
   assign start_eff = i_key_start & ~i_key_pause & ~i_key_stop;

   always_comb begin
      state_d      = state_q;
      end_addr_d   = end_addr_q;
      rec_valid_d  = rec_valid_q;
      rec_start_d  = 1'b0;
      rec_pause_d  = 1'b0;
      rec_stop_d   = 1'b0;
      play_start_d = 1'b0;
      play_pause_d = 1'b0;
      play_stop_d  = 1'b0;
      case (state_q)
         S_INIT: begin
            if (i_init_done) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (start_eff) begin
               if (i_mode_rec) begin
                  state_d     = S_REC;
                  rec_start_d = 1'b1;
               end else if (rec_valid_q) begin
                  state_d      = S_PLAY;
                  play_start_d = 1'b1;
               end
            end
         end
         S_REC: begin
            // Hitting the last SRAM word ends the take like a stop key.
            if (i_key_stop || (i_rec_addr == MAX_ADDR)) begin
               state_d     = S_IDLE;
               rec_stop_d  = 1'b1;
               end_addr_d  = i_rec_addr;
               rec_valid_d = 1'b1;
            end else if (i_key_pause) begin
               state_d     = S_REC_PAUSE;
               rec_pause_d = 1'b1;
            end
         end
         S_REC_PAUSE: begin
            if (i_key_stop) begin
               state_d     = S_IDLE;
               rec_stop_d  = 1'b1;
               end_addr_d  = i_rec_addr;
               rec_valid_d = 1'b1;
            end else if (start_eff) begin
               state_d     = S_REC;
               rec_start_d = 1'b1;
            end
         end
         S_PLAY: begin
            if (i_key_stop || i_play_done) begin
               state_d     = S_IDLE;
               play_stop_d = 1'b1;
            end else if (i_key_pause) begin
               state_d      = S_PLAY_PAUSE;
               play_pause_d = 1'b1;
            end
         end
         S_PLAY_PAUSE: begin
            if (i_key_stop) begin
               state_d     = S_IDLE;
               play_stop_d = 1'b1;
            end else if (start_eff) begin
               state_d      = S_PLAY;
               play_start_d = 1'b1;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= S_INIT;
         end_addr_q   <= '0;
         rec_valid_q  <= 1'b0;
         rec_start_q  <= 1'b0;
         rec_pause_q  <= 1'b0;
         rec_stop_q   <= 1'b0;
         play_start_q <= 1'b0;
         play_pause_q <= 1'b0;
         play_stop_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         end_addr_q   <= end_addr_d;
         rec_valid_q  <= rec_valid_d;
         rec_start_q  <= rec_start_d;
         rec_pause_q  <= rec_pause_d;
         rec_stop_q   <= rec_stop_d;
         play_start_q <= play_start_d;
         play_pause_q <= play_pause_d;
         play_stop_q  <= play_stop_d;
      end
   end

   assign o_rec_start  = rec_start_q;
   assign o_rec_pause  = rec_pause_q;
   assign o_rec_stop   = rec_stop_q;
   assign o_play_start = play_start_q;
   assign o_play_pause = play_pause_q;
   assign o_play_stop  = play_stop_q;
   assign o_end_addr   = end_addr_q;
   assign o_rec_valid  = rec_valid_q;
   assign o_state      = state_q;

   // SRAM port follows the registered state so the write strobe can never
   // glitch on a key edge; the recorder keeps the port while paused.
   logic rec_owns;
   assign rec_owns     = (state_q == S_REC) || (state_q == S_REC_PAUSE);
   assign o_sram_addr  = rec_owns ? i_rec_addr : i_play_addr;
   assign o_sram_wdata = rec_owns ? i_rec_data : 16'h0000;
   assign o_sram_we_n  = (state_q != S_REC);

endmodule

// File: tb/tb_aud_mode_ctrl.sv
module tb_aud_mode_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        init_done, key_start, key_pause, key_stop, mode_rec;
   logic [19:0] rec_addr, play_addr;
   logic [15:0] rec_data;
   logic        play_done;
   logic        rec_start, rec_pause, rec_stop;
   logic        play_start, play_pause, play_stop;
   logic [19:0] end_addr, sram_addr;
   logic        rec_valid, sram_we_n;
   logic [15:0] sram_wdata;
   logic [2:0]  state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aud_mode_ctrl #(.ADDR_W(20), .MAX_ADDR(20'hFFFFF)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_init_done(init_done),
      .i_key_start(key_start), .i_key_pause(key_pause), .i_key_stop(key_stop),
      .i_mode_rec(mode_rec),
      .o_rec_start(rec_start), .o_rec_pause(rec_pause), .o_rec_stop(rec_stop),
      .i_rec_addr(rec_addr), .i_rec_data(rec_data),
      .o_play_start(play_start), .o_play_pause(play_pause), .o_play_stop(play_stop),
      .i_play_addr(play_addr), .i_play_done(play_done),
      .o_end_addr(end_addr), .o_rec_valid(rec_valid),
      .o_sram_addr(sram_addr), .o_sram_we_n(sram_we_n), .o_sram_wdata(sram_wdata),
      .o_state(state)
   );

   // keys = {start, pause, stop}; pulses = {rec_start, rec_pause, rec_stop,
   // play_start, play_pause, play_stop}
   typedef struct {
      logic        init;
      logic [2:0]  keys;
      logic        mode;
      logic [19:0] raddr;
      logic [15:0] rdata;
      logic [19:0] paddr;
      logic        pdone;
      logic [2:0]  e_state;
      logic [5:0]  e_pulses;
      logic        e_we_n;
      logic [19:0] e_saddr;
      logic [15:0] e_wdata;
      logic [19:0] e_end;
      logic        e_valid;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic init, logic [2:0] keys, logic mode,
                               logic [19:0] raddr, logic [15:0] rdata,
                               logic [19:0] paddr, logic pdone,
                               logic [2:0] e_state, logic [5:0] e_pulses,
                               logic e_we_n, logic [19:0] e_saddr,
                               logic [15:0] e_wdata, logic [19:0] e_end,
                               logic e_valid);
      vec_t v;
      v.init = init; v.keys = keys; v.mode = mode; v.raddr = raddr;
      v.rdata = rdata; v.paddr = paddr; v.pdone = pdone;
      v.e_state = e_state; v.e_pulses = e_pulses; v.e_we_n = e_we_n;
      v.e_saddr = e_saddr; v.e_wdata = e_wdata; v.e_end = e_end;
      v.e_valid = e_valid;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_pulses();
      key_start = 1'b0; key_pause = 1'b0; key_stop = 1'b0; play_done = 1'b0;
   endtask

   // Drive one vector just after a rising edge, let one edge act on it, then
   // sample 1 time unit after that edge while inputs are still held.
   task automatic apply(input int idx, input vec_t v);
      string tag;
      init_done = v.init;
      {key_start, key_pause, key_stop} = v.keys;
      mode_rec = v.mode; rec_addr = v.raddr; rec_data = v.rdata;
      play_addr = v.paddr; play_done = v.pdone;
      @(posedge clk); #1;
      tag = $sformatf("v%0d", idx);
      check({tag, ".state"}, 32'(state), 32'(v.e_state));
      check({tag, ".pulses"}, 32'({rec_start, rec_pause, rec_stop,
                                   play_start, play_pause, play_stop}), 32'(v.e_pulses));
      check({tag, ".we_n"}, 32'(sram_we_n), 32'(v.e_we_n));
      check({tag, ".sram_addr"}, 32'(sram_addr), 32'(v.e_saddr));
      check({tag, ".sram_wdata"}, 32'(sram_wdata), 32'(v.e_wdata));
      check({tag, ".end_addr"}, 32'(end_addr), 32'(v.e_end));
      check({tag, ".rec_valid"}, 32'(rec_valid), 32'(v.e_valid));
      clear_pulses();
   endtask

   localparam logic [2:0] K_NONE = 3'b000, K_START = 3'b100, K_PAUSE = 3'b010,
                          K_STOP = 3'b001, K_ALL = 3'b111, K_PS = 3'b011;
   localparam logic [5:0] P_NONE = 6'b000000, P_RSTART = 6'b100000,
                          P_RPAUSE = 6'b010000, P_RSTOP = 6'b001000,
                          P_PSTART = 6'b000100, P_PPAUSE = 6'b000010,
                          P_PSTOP = 6'b000001;

   initial begin
      // init keys raddr rdata paddr pdone | state pulses we_n saddr wdata end valid
      vecs.push_back(mk(0, K_START, 1, 20'h0, 16'h0, 20'h0, 0, 0, P_NONE, 1, 20'h0, 16'h0, 20'h0, 0));
      vecs.push_back(mk(0, K_STOP, 1, 20'h0, 16'h0, 20'h0, 0, 0, P_NONE, 1, 20'h0, 16'h0, 20'h0, 0));
      vecs.push_back(mk(1, K_NONE, 0, 20'h0, 16'h0, 20'h0, 0, 1, P_NONE, 1, 20'h0, 16'h0, 20'h0, 0));
      // play with no recording is ignored; pause/stop in idle ignored
      vecs.push_back(mk(1, K_START, 0, 20'h0, 16'h0, 20'h3, 0, 1, P_NONE, 1, 20'h3, 16'h0, 20'h0, 0));
      vecs.push_back(mk(1, K_PS, 1, 20'h0, 16'h0, 20'h0, 0, 1, P_NONE, 1, 20'h0, 16'h0, 20'h0, 0));
      // record, pause, resume, stop at 0x123
      vecs.push_back(mk(1, K_START, 1, 20'h00010, 16'hBEEF, 20'h0, 0, 2, P_RSTART, 0, 20'h00010, 16'hBEEF, 20'h0, 0));
      vecs.push_back(mk(1, K_NONE, 1, 20'h00011, 16'h1234, 20'h0, 0, 2, P_NONE, 0, 20'h00011, 16'h1234, 20'h0, 0));
      vecs.push_back(mk(1, K_PAUSE, 1, 20'h00020, 16'hBEEF, 20'h0, 0, 3, P_RPAUSE, 1, 20'h00020, 16'hBEEF, 20'h0, 0));
      vecs.push_back(mk(1, K_START, 1, 20'h00021, 16'h5555, 20'h0, 0, 2, P_RSTART, 0, 20'h00021, 16'h5555, 20'h0, 0));
      vecs.push_back(mk(1, K_STOP, 1, 20'h00123, 16'hAAAA, 20'h00005, 0, 1, P_RSTOP, 1, 20'h00005, 16'h0, 20'h00123, 1));
      // play, pause, resume, done
      vecs.push_back(mk(1, K_START, 0, 20'h0, 16'h0, 20'h00007, 0, 4, P_PSTART, 1, 20'h00007, 16'h0, 20'h00123, 1));
      vecs.push_back(mk(1, K_PAUSE, 0, 20'h0, 16'h0, 20'h00008, 0, 5, P_PPAUSE, 1, 20'h00008, 16'h0, 20'h00123, 1));
      vecs.push_back(mk(1, K_START, 0, 20'h0, 16'h0, 20'h00009, 0, 4, P_PSTART, 1, 20'h00009, 16'h0, 20'h00123, 1));
      vecs.push_back(mk(1, K_NONE, 0, 20'h0, 16'h0, 20'h00123, 1, 1, P_PSTOP, 1, 20'h00123, 16'h0, 20'h00123, 1));
      // new recording keeps old end/valid until it ends; all keys -> stop only
      vecs.push_back(mk(1, K_START, 1, 20'h00100, 16'h0101, 20'h0, 0, 2, P_RSTART, 0, 20'h00100, 16'h0101, 20'h00123, 1));
      vecs.push_back(mk(1, K_ALL, 1, 20'h00200, 16'h0202, 20'h0, 0, 1, P_RSTOP, 1, 20'h0, 16'h0, 20'h00200, 1));
      // pause with play_done -> stop wins
      vecs.push_back(mk(1, K_START, 0, 20'h0, 16'h0, 20'h00010, 0, 4, P_PSTART, 1, 20'h00010, 16'h0, 20'h00200, 1));
      vecs.push_back(mk(1, K_PAUSE, 0, 20'h0, 16'h0, 20'h00011, 1, 1, P_PSTOP, 1, 20'h00011, 16'h0, 20'h00200, 1));
      // auto-stop at MAX_ADDR beats a coincident pause
      vecs.push_back(mk(1, K_START, 1, 20'h00300, 16'h0303, 20'h0, 0, 2, P_RSTART, 0, 20'h00300, 16'h0303, 20'h00200, 1));
      vecs.push_back(mk(1, K_PAUSE, 1, 20'hFFFFF, 16'h0404, 20'h0, 0, 1, P_RSTOP, 1, 20'h0, 16'h0, 20'hFFFFF, 1));
      // stop from record-pause latches address
      vecs.push_back(mk(1, K_START, 1, 20'h00400, 16'h0505, 20'h0, 0, 2, P_RSTART, 0, 20'h00400, 16'h0505, 20'hFFFFF, 1));
      vecs.push_back(mk(1, K_PAUSE, 1, 20'h00400, 16'h0505, 20'h0, 0, 3, P_RPAUSE, 1, 20'h00400, 16'h0505, 20'hFFFFF, 1));
      vecs.push_back(mk(1, K_STOP, 1, 20'h00444, 16'h0606, 20'h0, 0, 1, P_RSTOP, 1, 20'h0, 16'h0, 20'h00444, 1));
      // play stop key, stop from play-pause, then leave it playing
      vecs.push_back(mk(1, K_START, 0, 20'h0, 16'h0, 20'h00001, 0, 4, P_PSTART, 1, 20'h00001, 16'h0, 20'h00444, 1));
      vecs.push_back(mk(1, K_STOP, 0, 20'h0, 16'h0, 20'h00002, 0, 1, P_PSTOP, 1, 20'h00002, 16'h0, 20'h00444, 1));
      vecs.push_back(mk(1, K_START, 0, 20'h0, 16'h0, 20'h00003, 0, 4, P_PSTART, 1, 20'h00003, 16'h0, 20'h00444, 1));
      vecs.push_back(mk(1, K_PAUSE, 0, 20'h0, 16'h0, 20'h00004, 0, 5, P_PPAUSE, 1, 20'h00004, 16'h0, 20'h00444, 1));
      vecs.push_back(mk(1, K_STOP, 0, 20'h0, 16'h0, 20'h00005, 0, 1, P_PSTOP, 1, 20'h00005, 16'h0, 20'h00444, 1));
      vecs.push_back(mk(1, K_START, 0, 20'h0, 16'h0, 20'h00006, 0, 4, P_PSTART, 1, 20'h00006, 16'h0, 20'h00444, 1));
      vecs.push_back(mk(1, K_NONE, 0, 20'h0, 16'h0, 20'h00007, 0, 4, P_NONE, 1, 20'h00007, 16'h0, 20'h00444, 1));

      // reset values
      rst_n = 1'b0; init_done = 1'b0; mode_rec = 1'b0;
      rec_addr = '0; rec_data = '0; play_addr = '0;
      clear_pulses();
      repeat (3) @(posedge clk);
      #1;
      check("rst.state", 32'(state), 32'd0);
      check("rst.we_n", 32'(sram_we_n), 32'd1);
      check("rst.sram_addr", 32'(sram_addr), 32'd0);
      check("rst.sram_wdata", 32'(sram_wdata), 32'd0);
      check("rst.end_addr", 32'(end_addr), 32'd0);
      check("rst.rec_valid", 32'(rec_valid), 32'd0);
      check("rst.pulses", 32'({rec_start, rec_pause, rec_stop, play_start, play_pause, play_stop}), 32'd0);
      rst_n = 1'b1;

      foreach (vecs[i]) apply(i, vecs[i]);

      // async reset mid-play, between edges
      #3;
      rst_n = 1'b0;
      #1;
      check("arst.state", 32'(state), 32'd0);
      check("arst.we_n", 32'(sram_we_n), 32'd1);
      check("arst.rec_valid", 32'(rec_valid), 32'd0);
      check("arst.end_addr", 32'(end_addr), 32'd0);
      check("arst.pulses", 32'({rec_start, rec_pause, rec_stop, play_start, play_pause, play_stop}), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // after reset, init already high: idle next cycle, play still refused
      init_done = 1'b1;
      @(posedge clk); #1;
      check("reinit.state", 32'(state), 32'd1);
      key_start = 1'b1; mode_rec = 1'b0;
      @(posedge clk); #1;
      check("noplay.state", 32'(state), 32'd1);
      check("noplay.play_start", 32'(play_start), 32'd0);
      clear_pulses();
      @(posedge clk); #1;
      check("noplay.idle_hold", 32'(state), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule

// File: doc/aud_mode_ctrl.md
Name: aud_mode_ctrl

Overview:
- Top-level sequencer for the lab3 audio path.
- Converts debounced key pulses into start/pause/stop pulses for the recorder and the player/DSP.
- Owns the single SRAM port: muxes recorder writes and player reads onto it.
- Latches the recording end address so playback knows where to stop. Sits between the key/debounce logic, the I2C initializer, the recorder, the player/DSP and the SRAM interface.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- MAX_ADDR, 20'hFFFFF, last writable SRAM word. Reaching it auto-stops recording.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  asynchronous active-low reset
- i_init_done  input  1  level; I2C codec initialization complete
- i_key_start  input  1  one-cycle pulse
- i_key_pause  input  1  one-cycle pulse
- i_key_stop  input  1  one-cycle pulse
- i_mode_rec  input  1  1 = record, 0 = play; sampled only on start from S_IDLE
- o_rec_start  output  1  one-cycle pulse to recorder
- o_rec_pause  output  1  one-cycle pulse to recorder
- o_rec_stop  output  1  one-cycle pulse to recorder
- i_rec_addr  input  ADDR_W  recorder current write address
- i_rec_data  input  16  recorder sample
- o_play_start  output  1  one-cycle pulse to player/DSP
- o_play_pause  output  1  one-cycle pulse to player/DSP
- o_play_stop  output  1  one-cycle pulse to player/DSP
- i_play_addr  input  ADDR_W  player current read address
- i_play_done  input  1  one-cycle pulse; player reached o_end_addr
- o_end_addr  output  ADDR_W  latched last recorded address
- o_rec_valid  output  1  a recording exists
- o_sram_addr  output  ADDR_W  SRAM address
- o_sram_we_n  output  1  SRAM write enable, active low
- o_sram_wdata  output  16  SRAM write data
- o_state  output  3  current state, for display

Behaviour:
- Reset values:
  - state = S_INIT.
  - All pulse outputs 0.
  - o_end_addr = 0; o_rec_valid = 0.
  - o_sram_we_n = 1; o_sram_addr = 0; o_sram_wdata = 0.
  - Reset mid-operation aborts immediately; no stop pulse is issued.
- State encodings: S_INIT=0, S_IDLE=1, S_REC=2, S_REC_PAUSE=3, S_PLAY=4, S_PLAY_PAUSE=5.
- Key priority when keys coincide in one cycle: stop > pause > start. Only the highest-priority key acts.
- Pulse outputs are registered. Each is high exactly one cycle, in the cycle after the causing event, coincident with the new state.
- S_INIT:
  - All keys ignored.
  - i_init_done = 1 -> S_IDLE next cycle.
- S_IDLE:
  - start with i_mode_rec=1 -> S_REC, o_rec_start.
  - start with i_mode_rec=0 and o_rec_valid=1 -> S_PLAY, o_play_start.
  - start with i_mode_rec=0 and o_rec_valid=0 -> ignored, stay in S_IDLE.
  - pause and stop -> ignored.
- S_REC:
  - stop -> S_IDLE, o_rec_stop. Latch o_end_addr = i_rec_addr; set o_rec_valid = 1.
  - pause -> S_REC_PAUSE, o_rec_pause.
  - i_rec_addr == MAX_ADDR -> same as stop. Auto-stop beats a pause arriving in the same cycle.
- S_REC_PAUSE:
  - start -> S_REC, o_rec_start.
  - stop -> S_IDLE with the same latch behaviour as S_REC stop.
- S_PLAY:
  - stop or i_play_done -> S_IDLE, o_play_stop.
  - pause -> S_PLAY_PAUSE, o_play_pause.
  - i_play_done beats pause in the same cycle.
- S_PLAY_PAUSE:
  - start -> S_PLAY, o_play_start.
  - stop -> S_IDLE, o_play_stop.
- SRAM mux: combinational from the registered state.
  - S_REC, S_REC_PAUSE: o_sram_addr = i_rec_addr, o_sram_wdata = i_rec_data.
  - S_REC only: o_sram_we_n = 0.
  - All other states: o_sram_addr = i_play_addr, o_sram_wdata = 0, o_sram_we_n = 1.
- o_end_addr and o_rec_valid hold until the next recording ends, or until reset.
- A new recording does not clear o_rec_valid until it ends.
- o_state = state register.

Test Plan:
- Init gating: reset, pulse start with i_init_done=0 -> no pulses, o_state=0. Raise i_init_done -> o_state=1 next cycle.
- Record/stop: idle, mode_rec=1, start -> o_rec_start for one cycle, o_state=2, o_sram_we_n=0. Drive i_rec_addr=20'h00123, stop -> o_rec_stop, o_end_addr=20'h00123, o_rec_valid=1, o_sram_we_n=1.
- Play without recording: after reset and init, mode_rec=0, start -> stays o_state=1, no o_play_start.
- Play/pause/done: after the record scenario, start with mode_rec=0 -> o_play_start, o_sram_addr tracks i_play_addr. Pause -> o_state=5. Start -> o_state=4. i_play_done -> o_play_stop, o_state=1.
- Simultaneous keys: in S_REC, pulse stop+pause+start together -> only o_rec_stop, o_state=1. In S_PLAY, pause with i_play_done in the same cycle -> o_play_stop, o_state=1.
- Auto-stop and async reset:
  - S_REC with i_rec_addr=20'hFFFFF -> o_rec_stop, o_end_addr=20'hFFFFF.
  - Assert i_rst_n=0 mid-S_PLAY, between clock edges -> o_state=0 and o_sram_we_n=1 immediately, o_rec_valid=0.
